// File: rtl/audio_dac_fifo_port_pkg.sv
// Shared constants for the audio DAC FIFO port: register addresses, register bit
// positions and default parameter values.
package audio_pkg;

  localparam logic [1:0] ADDR_DATA      = 2'd0;
  localparam logic [1:0] ADDR_STATUS    = 2'd1;
  localparam logic [1:0] ADDR_CONTROL   = 2'd2;
  localparam logic [1:0] ADDR_THRESHOLD = 2'd3;

  localparam int unsigned STAT_EMPTY_BIT = 16;
  localparam int unsigned STAT_FULL_BIT  = 17;
  localparam int unsigned STAT_OVF_BIT   = 18;
  localparam int unsigned STAT_UDF_BIT   = 19;
  localparam int unsigned STAT_IRQ_BIT   = 20;

  localparam int unsigned CTRL_EN_BIT     = 0;
  localparam int unsigned CTRL_CLEAR_BIT  = 1;
  localparam int unsigned CTRL_IRQ_EN_BIT = 2;

  localparam int unsigned DEF_DATA_W   = 32;
  localparam int unsigned DEF_DEPTH    = 16;
  localparam int unsigned DEF_CHANNELS = 2;

endpackage

// File: rtl/audio_dac_fifo_port_if.sv
// Avalon-MM slave bus bundle for the audio DAC FIFO port.
interface audio_dac_fifo_port_if;

  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );

endinterface

// File: rtl/audio_sample_fifo.sv
// Synchronous register-array FIFO with synchronous clear; a pop while empty and a
// push while full (without a pop) are both ignored.
module audio_sample_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 16,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] head_o,
  output logic [CNT_W-1:0]  count_o,
  output logic              full_o,
  output logic              empty_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  // A pop in the same cycle frees the slot a full-FIFO push needs.
  assign pop_ok  = pop_i & ~empty_o & ~clr_i;
  assign push_ok = push_i & (~full_o | pop_ok) & ~clr_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Sample storage needs no reset: it is only observable through valid entries.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/audio_dac_fifo_port.sv
// Audio DAC sample port: CPU-fed FIFO drained one sample per codec tick, with
// round-robin channel tagging, sticky error flags and a low-watermark interrupt.
module audio_dac_fifo_port
  import audio_pkg::*;
#(
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned CHANNELS = DEF_CHANNELS,
  localparam int unsigned CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  audio_dac_fifo_port_if.slave bus,
  input  logic                 sample_tick,
  output logic [DATA_W-1:0]    out_port,
  output logic [CH_W-1:0]      out_channel,
  output logic                 out_strobe,
  output logic                 irq
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [31:0]       wd;
  logic              wr_en, wr_data, wr_status, wr_control, wr_thresh;
  logic              clear, tick_act, fifo_pop;
  logic [DATA_W-1:0] fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;
  logic [31:0]       status;

  logic              enable_q, enable_d;
  logic              irq_en_q, irq_en_d;
  logic [CNT_W-1:0]  thresh_q, thresh_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              irq_q, irq_d;
  logic              out_strobe_q, out_strobe_d;
  logic [DATA_W-1:0] out_port_q, out_port_d;
  logic [CH_W-1:0]   out_channel_q, out_channel_d;
  logic [CH_W-1:0]   ch_next_q, ch_next_d;

  assign wd         = bus.writedata;
  assign wr_en      = bus.chipselect & ~bus.write_n;
  assign wr_data    = wr_en & (bus.address == ADDR_DATA);
  assign wr_status  = wr_en & (bus.address == ADDR_STATUS);
  assign wr_control = wr_en & (bus.address == ADDR_CONTROL);
  assign wr_thresh  = wr_en & (bus.address == ADDR_THRESHOLD);
  assign clear      = wr_control & wd[CTRL_CLEAR_BIT];
  // A tick coinciding with a clear is dropped entirely.
  assign tick_act   = sample_tick & enable_q & ~clear;
  assign fifo_pop   = tick_act & ~fifo_empty;

  audio_sample_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clr_i   (clear),
    .push_i  (wr_data),
    .wdata_i (wd[DATA_W-1:0]),
    .pop_i   (fifo_pop),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_comb begin
    enable_d      = enable_q;
    irq_en_d      = irq_en_q;
    thresh_d      = thresh_q;
    ovf_d         = ovf_q;
    udf_d         = udf_q;
    out_port_d    = out_port_q;
    out_channel_d = out_channel_q;
    ch_next_d     = ch_next_q;
    out_strobe_d  = tick_act;
    irq_d         = irq_en_q & enable_q & (fifo_count <= thresh_q);

    if (wr_control) begin
      enable_d = wd[CTRL_EN_BIT];
      irq_en_d = wd[CTRL_IRQ_EN_BIT];
    end
    if (wr_thresh) thresh_d = wd[CNT_W-1:0];
    if (wr_status) begin
      if (wd[STAT_OVF_BIT]) ovf_d = 1'b0;
      if (wd[STAT_UDF_BIT]) udf_d = 1'b0;
    end
    if (wr_data && fifo_full && !fifo_pop) ovf_d = 1'b1;

    // Channel tag advances even on underflow to keep the codec frame aligned.
    if (tick_act) begin
      if (fifo_empty) udf_d = 1'b1;
      else            out_port_d = fifo_head;
      out_channel_d = ch_next_q;
      ch_next_d     = (ch_next_q == CH_W'(CHANNELS - 1)) ? '0 : ch_next_q + 1'b1;
    end
    if (clear) begin
      out_port_d    = '0;
      out_channel_d = '0;
      ch_next_d     = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q      <= 1'b0;
      irq_en_q      <= 1'b0;
      thresh_q      <= '0;
      ovf_q         <= 1'b0;
      udf_q         <= 1'b0;
      irq_q         <= 1'b0;
      out_strobe_q  <= 1'b0;
      out_port_q    <= '0;
      out_channel_q <= '0;
      ch_next_q     <= '0;
    end else begin
      enable_q      <= enable_d;
      irq_en_q      <= irq_en_d;
      thresh_q      <= thresh_d;
      ovf_q         <= ovf_d;
      udf_q         <= udf_d;
      irq_q         <= irq_d;
      out_strobe_q  <= out_strobe_d;
      out_port_q    <= out_port_d;
      out_channel_q <= out_channel_d;
      ch_next_q     <= ch_next_d;
    end
  end

  assign out_port    = out_port_q;
  assign out_channel = out_channel_q;
  assign out_strobe  = out_strobe_q;
  assign irq         = irq_q;

  always_comb begin
    status                 = '0;
    status[15:0]           = 16'(fifo_count);
    status[STAT_EMPTY_BIT] = fifo_empty;
    status[STAT_FULL_BIT]  = fifo_full;
    status[STAT_OVF_BIT]   = ovf_q;
    status[STAT_UDF_BIT]   = udf_q;
    status[STAT_IRQ_BIT]   = irq_q;
  end

  always_comb begin
    bus.readdata = '0;
    unique case (bus.address)
      ADDR_DATA:      bus.readdata = 32'(out_port_q);
      ADDR_STATUS:    bus.readdata = status;
      ADDR_CONTROL: begin
        bus.readdata[CTRL_EN_BIT]     = enable_q;
        bus.readdata[CTRL_IRQ_EN_BIT] = irq_en_q;
      end
      ADDR_THRESHOLD: bus.readdata = 32'(thresh_q);
      default:        bus.readdata = '0;
    endcase
  end

endmodule

// File: tb/tb_audio_dac_fifo_port.sv
// Randomised self-checking bench for audio_dac_fifo_port against a queue-based model.
module tb_audio_dac_fifo_port;

  localparam int DATA_W   = 32;
  localparam int DEPTH    = 16;
  localparam int CHANNELS = 2;
  localparam int CH_W     = 1;

  logic              clk;
  logic              reset_n;
  logic              sample_tick;
  logic [DATA_W-1:0] out_port;
  logic [CH_W-1:0]   out_channel;
  logic              out_strobe;
  logic              irq;

  audio_dac_fifo_port_if bus_if ();

  audio_dac_fifo_port #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .CHANNELS (CHANNELS)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .bus         (bus_if),
    .sample_tick (sample_tick),
    .out_port    (out_port),
    .out_channel (out_channel),
    .out_strobe  (out_strobe),
    .irq         (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  logic [31:0] m_q[$];
  logic [31:0] m_out;
  int          m_ch, m_next, m_thr;
  bit          m_en, m_irq_en, m_ovf, m_udf, m_irq, m_strobe;

  task automatic model_reset();
    m_q.delete();
    m_out = '0; m_ch = 0; m_next = 0; m_thr = 0;
    m_en = 0; m_irq_en = 0; m_ovf = 0; m_udf = 0; m_irq = 0; m_strobe = 0;
  endtask

  task automatic model_step(input bit wr, input logic [1:0] addr, input logic [31:0] data,
                            input bit tick);
    bit was_empty, was_full, t, popped;
    was_empty = (m_q.size() == 0);
    was_full  = (m_q.size() == DEPTH);
    t         = tick && m_en && !(wr && addr == 2'd2 && data[1]);
    popped    = 0;
    m_irq     = m_irq_en && m_en && (m_q.size() <= m_thr);
    m_strobe  = t;
    if (wr && addr == 2'd1) begin
      if (data[18]) m_ovf = 0;
      if (data[19]) m_udf = 0;
    end
    if (t) begin
      if (!was_empty) begin
        m_out  = m_q.pop_front();
        popped = 1;
      end else begin
        m_udf = 1;
      end
      m_ch   = m_next;
      m_next = (m_next + 1) % CHANNELS;
    end
    if (wr && addr == 2'd0) begin
      if (was_full && !popped) m_ovf = 1;
      else m_q.push_back(data);
    end
    if (wr && addr == 2'd2) begin
      m_en     = data[0];
      m_irq_en = data[2];
      if (data[1]) begin
        m_q.delete();
        m_out = '0; m_ch = 0; m_next = 0;
      end
    end
    if (wr && addr == 2'd3) m_thr = int'(data[4:0]);
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s       = '0;
    s[15:0] = 16'(m_q.size());
    s[16]   = (m_q.size() == 0);
    s[17]   = (m_q.size() == DEPTH);
    s[18]   = m_ovf;
    s[19]   = m_udf;
    s[20]   = m_irq;
    return s;
  endfunction

  // One clock: drive bus/tick, advance model at the edge, sample 1 time unit after.
  task automatic step(input bit wr, input logic [1:0] addr, input logic [31:0] data,
                      input bit tick);
    bus_if.chipselect = wr;
    bus_if.write_n    = ~wr;
    bus_if.address    = addr;
    bus_if.writedata  = data;
    sample_tick       = tick;
    @(posedge clk);
    model_step(wr, addr, data, tick);
    #1;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    sample_tick       = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] addr, output logic [31:0] data);
    bus_if.address = addr;
    #1;
    data = bus_if.readdata;
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_checks += 4;
    if (out_port !== '0) begin n_errors++; $display("FAIL reset_out_port: got %h want 0", out_port); end
    if (out_channel !== '0) begin n_errors++; $display("FAIL reset_out_channel: got %h want 0", out_channel); end
    if (out_strobe !== 1'b0) begin n_errors++; $display("FAIL reset_strobe: got %b want 0", out_strobe); end
    if (irq !== 1'b0) begin n_errors++; $display("FAIL reset_irq: got %b want 0", irq); end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0001_0000) begin n_errors++; $display("FAIL reset_status: got %h want 00010000", rd); end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_control: got %h want 0", rd); end
    bus_read(2'd3, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL reset_threshold: got %h want 0", rd); end
    #5 reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_prefill_drain();
    logic [31:0] vals[3];
    logic [31:0] rd;
    vals = '{32'h11, 32'h22, 32'h33};
    for (int i = 0; i < 3; i++) step(1, 2'd0, vals[i], 0);
    bus_read(2'd1, rd);
    n_checks++;
    if (rd[15:0] !== 16'd3) begin n_errors++; $display("FAIL prefill_count: got %0d want 3", rd[15:0]); end
    step(1, 2'd2, 32'h1, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 2'd0, 32'h0, 1);
      n_checks += 3;
      if (out_port !== vals[i]) begin n_errors++; $display("FAIL drain_data[%0d]: got %h want %h", i, out_port, vals[i]); end
      if (out_channel !== CH_W'(i % 2)) begin n_errors++; $display("FAIL drain_channel[%0d]: got %0d want %0d", i, out_channel, i % 2); end
      if (out_strobe !== 1'b1) begin n_errors++; $display("FAIL drain_strobe[%0d]: got %b want 1", i, out_strobe); end
    end
    step(0, 2'd0, 32'h0, 0);
    n_checks++;
    if (out_strobe !== 1'b0) begin n_errors++; $display("FAIL drain_strobe_idle: got %b want 0", out_strobe); end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd[16] !== 1'b1) begin n_errors++; $display("FAIL drain_empty: got %b want 1", rd[16]); end
  endtask

  task automatic test_underflow();
    logic [31:0] rd;
    step(0, 2'd0, 32'h0, 1);
    bus_read(2'd1, rd);
    n_checks += 4;
    if (out_port !== 32'h33) begin n_errors++; $display("FAIL udf_hold: got %h want 33", out_port); end
    if (out_channel !== 1'b1) begin n_errors++; $display("FAIL udf_channel: got %0d want 1", out_channel); end
    if (out_strobe !== 1'b1) begin n_errors++; $display("FAIL udf_strobe: got %b want 1", out_strobe); end
    if (rd[19] !== 1'b1) begin n_errors++; $display("FAIL udf_flag: got %b want 1", rd[19]); end
    step(1, 2'd2, 32'h0, 0);
    step(0, 2'd0, 32'h0, 1);
    n_checks += 3;
    if (out_port !== 32'h33) begin n_errors++; $display("FAIL disabled_hold: got %h want 33", out_port); end
    if (out_channel !== 1'b1) begin n_errors++; $display("FAIL disabled_channel: got %0d want 1", out_channel); end
    if (out_strobe !== 1'b0) begin n_errors++; $display("FAIL disabled_strobe: got %b want 0", out_strobe); end
  endtask

  task automatic test_overflow();
    logic [31:0] words[17];
    logic [31:0] rd;
    step(1, 2'd1, 32'h000C_0000, 0);
    for (int i = 0; i < 17; i++) begin
      words[i] = $urandom;
      step(1, 2'd0, words[i], 0);
    end
    bus_read(2'd1, rd);
    n_checks += 4;
    if (rd[15:0] !== 16'd16) begin n_errors++; $display("FAIL ovf_count: got %0d want 16", rd[15:0]); end
    if (rd[17] !== 1'b1) begin n_errors++; $display("FAIL ovf_full: got %b want 1", rd[17]); end
    if (rd[18] !== 1'b1) begin n_errors++; $display("FAIL ovf_flag: got %b want 1", rd[18]); end
    if (rd !== model_status()) begin n_errors++; $display("FAIL ovf_status: got %h want %h", rd, model_status()); end
    step(1, 2'd1, 32'h0004_0000, 0);
    bus_read(2'd1, rd);
    n_checks++;
    if (rd[18] !== 1'b0) begin n_errors++; $display("FAIL ovf_clear: got %b want 0", rd[18]); end
    step(1, 2'd2, 32'h1, 0);
    for (int i = 0; i < 16; i++) begin
      step(0, 2'd0, 32'h0, 1);
      n_checks++;
      if (out_port !== words[i]) begin n_errors++; $display("FAIL ovf_order[%0d]: got %h want %h", i, out_port, words[i]); end
    end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== model_status()) begin n_errors++; $display("FAIL ovf_drained: got %h want %h", rd, model_status()); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] words[16];
    logic [31:0] rd, want;
    step(1, 2'd2, 32'h0, 0);
    for (int i = 0; i < 16; i++) begin
      words[i] = $urandom;
      step(1, 2'd0, words[i], 0);
    end
    step(1, 2'd2, 32'h1, 0);
    step(1, 2'd0, 32'hAA, 1);
    bus_read(2'd1, rd);
    n_checks += 3;
    if (out_port !== words[0]) begin n_errors++; $display("FAIL fpp_first: got %h want %h", out_port, words[0]); end
    if (rd[15:0] !== 16'd16) begin n_errors++; $display("FAIL fpp_count: got %0d want 16", rd[15:0]); end
    if (rd[18] !== 1'b0) begin n_errors++; $display("FAIL fpp_no_ovf: got %b want 0", rd[18]); end
    for (int i = 0; i < 16; i++) begin
      step(0, 2'd0, 32'h0, 1);
      want = (i < 15) ? words[i + 1] : 32'hAA;
      n_checks++;
      if (out_port !== want) begin n_errors++; $display("FAIL fpp_order[%0d]: got %h want %h", i, out_port, want); end
    end
  endtask

  task automatic test_watermark_irq();
    logic [31:0] rd;
    step(1, 2'd2, 32'h0, 0);
    step(1, 2'd3, 32'h4, 0);
    for (int i = 0; i < 6; i++) step(1, 2'd0, $urandom, 0);
    step(1, 2'd2, 32'h5, 0);
    step(0, 2'd0, 32'h0, 0);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL wm_above: got %b want 0", irq); end
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 1);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL wm_latency: got %b want 0", irq); end
    step(0, 2'd0, 32'h0, 0);
    bus_read(2'd1, rd);
    n_checks += 2;
    if (irq !== 1'b1) begin n_errors++; $display("FAIL wm_assert: got %b want 1", irq); end
    if (rd[15:0] !== 16'd4) begin n_errors++; $display("FAIL wm_count: got %0d want 4", rd[15:0]); end
    step(1, 2'd0, $urandom, 0);
    step(0, 2'd0, 32'h0, 0);
    n_checks++;
    if (irq !== 1'b0) begin n_errors++; $display("FAIL wm_deassert: got %b want 0", irq); end
  endtask

  task automatic test_random();
    logic [31:0] rd, data;
    logic [1:0]  addr;
    bit          wr, tick;
    for (int i = 0; i < 400; i++) begin
      wr   = ($urandom_range(0, 2) == 0);
      addr = 2'($urandom_range(0, 3));
      data = $urandom;
      if (addr == 2'd2 && $urandom_range(0, 7) != 0) data[1] = 1'b0;
      if (addr == 2'd2 && $urandom_range(0, 3) != 0) data[0] = 1'b1;
      tick = ($urandom_range(0, 1) == 1);
      step(wr, addr, data, tick);
      n_checks += 4;
      if (out_port !== m_out) begin n_errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, out_port, m_out); end
      if (out_channel !== CH_W'(m_ch)) begin n_errors++; $display("FAIL rnd_channel[%0d]: got %0d want %0d", i, out_channel, m_ch); end
      if (out_strobe !== m_strobe) begin n_errors++; $display("FAIL rnd_strobe[%0d]: got %b want %b", i, out_strobe, m_strobe); end
      if (irq !== m_irq) begin n_errors++; $display("FAIL rnd_irq[%0d]: got %b want %b", i, irq, m_irq); end
      if (i % 8 == 0) begin
        bus_read(2'd1, rd);
        n_checks++;
        if (rd !== model_status()) begin n_errors++; $display("FAIL rnd_status[%0d]: got %h want %h", i, rd, model_status()); end
      end
    end
  endtask

  task automatic test_clear_reset();
    logic [31:0] rd;
    step(1, 2'd1, 32'h000C_0000, 0);
    step(1, 2'd2, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(1, 2'd0, $urandom | 32'h1, 0);
    step(1, 2'd2, 32'h1, 0);
    step(0, 2'd0, 32'h0, 1);
    step(0, 2'd0, 32'h0, 1);
    step(1, 2'd2, 32'h3, 1);
    n_checks += 3;
    if (out_port !== '0) begin n_errors++; $display("FAIL clr_out_port: got %h want 0", out_port); end
    if (out_channel !== '0) begin n_errors++; $display("FAIL clr_channel: got %0d want 0", out_channel); end
    if (out_strobe !== 1'b0) begin n_errors++; $display("FAIL clr_tick_dropped: got %b want 0", out_strobe); end
    bus_read(2'd1, rd);
    n_checks++;
    if (rd[16:0] !== 17'h1_0000) begin n_errors++; $display("FAIL clr_count: got %h want 10000", rd[16:0]); end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h1) begin n_errors++; $display("FAIL clr_control: got %h want 1", rd); end
    for (int i = 0; i < 3; i++) step(1, 2'd0, $urandom | 32'h1, 0);
    step(1, 2'd3, 32'h1F, 0);
    step(1, 2'd2, 32'h5, 0);
    step(0, 2'd0, 32'h0, 1);
    n_checks += 2;
    if (out_strobe !== 1'b1 || irq !== 1'b1) begin n_errors++; $display("FAIL pre_reset_active: got strobe=%b irq=%b want 1 1", out_strobe, irq); end
    if (out_port !== m_out) begin n_errors++; $display("FAIL pre_reset_data: got %h want %h", out_port, m_out); end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    n_checks += 4;
    if (out_port !== '0) begin n_errors++; $display("FAIL areset_out_port: got %h want 0", out_port); end
    if (out_channel !== '0) begin n_errors++; $display("FAIL areset_channel: got %0d want 0", out_channel); end
    if (out_strobe !== 1'b0) begin n_errors++; $display("FAIL areset_strobe: got %b want 0", out_strobe); end
    if (irq !== 1'b0) begin n_errors++; $display("FAIL areset_irq: got %b want 0", irq); end
    #3 reset_n = 1'b1;
    @(posedge clk); #1;
    bus_read(2'd1, rd);
    n_checks++;
    if (rd !== 32'h0001_0000) begin n_errors++; $display("FAIL areset_status: got %h want 00010000", rd); end
    bus_read(2'd2, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_errors++; $display("FAIL areset_control: got %h want 0", rd); end
  endtask

  initial begin
    reset_n           = 1'b0;
    sample_tick       = 1'b0;
    bus_if.address    = 2'd0;
    bus_if.chipselect = 1'b0;
    bus_if.write_n    = 1'b1;
    bus_if.writedata  = '0;
    model_reset();
    #2;
    test_reset();
    test_prefill_drain();
    test_underflow();
    test_overflow();
    test_full_push_pop();
    test_watermark_irq();
    test_random();
    test_clear_reset();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
